snd_srcfetch: RTL
=================

// Module: snd_srcfetch
// PURPOSE
//  AXI4 read master feeding the sound source buffer: fetches 32-bit stereo samples ({L[31:16],R[15:0]}) from DRAM, writes them via srcBUF_WR/srcBUF_DIN.
//  Write side of the srcBUF interface; shares COMMAND with the buffer so clear/play stay in lockstep.
// PARAMETERS
//  BURST_LEN  16  beats per full AXI burst (1..256); bursts never cross a 4 KB boundary
//  ADDR_W     32  AXI address width
// PORTS
//  ACLK           in   1       clock
//  ARST           in   1       reset, synchronous, active-high
//  COMMAND        in   2       00 stop/pause, 01 play, 11 clear; other codes = stop
//  START_ADDR     in   ADDR_W  base byte address; BURST_LEN*4-aligned
//  DATA_BYTES     in   32      stream length in bytes; multiple of 4, nonzero
//  ARADDR         out  ADDR_W  AXI read address
//  ARLEN          out  8       beats-1
//  ARVALID        out  1       address valid
//  ARREADY        in   1       address ready
//  RDATA          in   32      read data
//  RRESP          in   2       read response
//  RLAST          in   1       last beat
//  RVALID         in   1       data valid
//  RREADY         out  1       data ready
//  srcBUF_WREADY  in   1       buffer has room for >= one full burst
//  srcBUF_WR      out  1       one-cycle write strobe
//  srcBUF_DIN     out  32      sample word
//  BUSY           out  1       burst outstanding
//  DONE           out  1       sticky: whole stream fetched (non-loop build)
//  ERR            out  1       sticky: RRESP != 00 seen
// BEHAVIOUR
//  Reset: all outputs 0; ptr=START_ADDR, rem=DATA_BYTES/4, state IDLE.
//  COMMAND registered once (com_r); all decisions use com_r (1-cycle latency, matches buffer).
//  FSM IDLE -> AR -> RD -> IDLE:
//   IDLE: com_r==01 & srcBUF_WREADY & rem!=0 & !DONE -> AR; ARLEN=min(rem,BURST_LEN)-1 latched.
//   AR: ARVALID=1, ARADDR/ARLEN stable until ARREADY; -> RD.
//   RD: RREADY=1 always (room guaranteed at issue); each RVALID beat: srcBUF_WR=1, srcBUF_DIN=RDATA, same cycle (0 latency, combinational pass).
//   RLAST beat -> IDLE; ptr+=beats*4, rem-=beats.
//  BUSY=1 in AR and RD.
//  Stop (00) mid-burst: finish burst normally, no new burst; resume on 01 from ptr.
//  Clear (11): in IDLE -> ptr=START_ADDR, rem=DATA_BYTES/4, DONE=0, ERR=0 next cycle.
//   In AR/RD: AXI not aborted; remaining beats accepted with srcBUF_WR suppressed, reload on RLAST.
//  RRESP!=00 on any beat: ERR=1; beat still written (data kept, flag only).
//  rem reaches 0: see CONFIGURATION.
//  RLAST/beat-count mismatch ignored; beat counter is informational, RLAST ends the burst.
//  START_ADDR/DATA_BYTES sampled only at reset and clear; changes otherwise ignored.
// CONFIGURATION
//  SND_SRCFETCH_LOOP_EN defined: on rem==0 in IDLE, reload ptr/rem from START_ADDR/DATA_BYTES, continue; DONE stays 0.
//  Not defined: rem==0 -> DONE=1, no further bursts until clear (11).
// STRUCTURE
//  snd_pkg: CMD_STOP=2'b00, CMD_PLAY=2'b01, CMD_CLEAR=2'b11, FSM state encoding, RESP_OKAY=2'b00.
//  Sub-module snd_srcfetch_burst: from ptr/rem/BURST_LEN yields beat count and ARLEN,
//   clamped to min(rem, BURST_LEN, words to next 4 KB boundary).
// TESTING
//  1 BURST_LEN=16, DATA_BYTES=256, play, ARREADY/RVALID=1 -> 4 bursts at +0,+64,+128,+192, 64 writes, DONE=1.
//  2 DATA_BYTES=100 -> ARLEN 15 then 8; 25 writes in order, DONE=1.
//  3 srcBUF_WREADY=0 -> no ARVALID; rises -> ARVALID next cycle; burst in flight when it falls completes.
//  4 COMMAND 11 at beat 5 of 16 -> beats 6..16 accepted, no srcBUF_WR; next play restarts at START_ADDR.
//  5 RRESP=2'b10 on one beat -> ERR=1, word still written; clear -> ERR=0.
//  6 LOOP_EN, DATA_BYTES=128 -> addresses +0,+64,+0,+64..., DONE stays 0; random ARREADY/RVALID stalls.

Source files
------------

// File: rtl/snd_pkg.sv
// rtl/snd_pkg.sv - shared command codes, response codes and fetch FSM encoding for the sound source path
package snd_pkg;

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_PLAY  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_RD   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/snd_srcfetch_burst.sv
// rtl/snd_srcfetch_burst.sv - next burst size: min(remaining words, BURST_LEN, words to the next 4 KB boundary)
module snd_srcfetch_burst #(
    parameter int BURST_LEN = 16
) (
    input  logic [9:0]  word_ofs_i,
    input  logic [29:0] rem_words_i,
    output logic [8:0]  beats_o,
    output logic [7:0]  arlen_o
);

    localparam logic [10:0] BURST_W = 11'(BURST_LEN);

    logic [10:0] to_bnd;
    logic [10:0] lim;

    always_comb begin
        // word_ofs_i is the word index within the current 4 KB page
        to_bnd  = 11'd1024 - {1'b0, word_ofs_i};
        lim     = (to_bnd < BURST_W) ? to_bnd : BURST_W;
        beats_o = (rem_words_i < {19'd0, lim}) ? rem_words_i[8:0] : lim[8:0];
        arlen_o = 8'(beats_o - 9'd1);
    end

endmodule

// File: rtl/snd_srcfetch.sv
// rtl/snd_srcfetch.sv - AXI4 read master streaming stereo samples into srcBUF; SND_SRCFETCH_LOOP_EN selects looped playback
module snd_srcfetch
    import snd_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [1:0]        COMMAND,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [31:0]       DATA_BYTES,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic              srcBUF_WREADY,
    output logic              srcBUF_WR,
    output logic [31:0]       srcBUF_DIN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    fetch_state_e      state_q, state_d;
    logic [1:0]        com_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [31:0]       rem_q, rem_d;
    logic [31:0]       len_q, len_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [8:0]        beats_q, beats_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              clrp_q, clrp_d;

    logic [8:0]        nb_beats;
    logic [7:0]        nb_arlen;
    logic              clr_cmd;
    logic              play_cmd;
    logic              wr;

    assign clr_cmd  = (com_q == CMD_CLEAR);
    assign play_cmd = (com_q == CMD_PLAY);

    snd_srcfetch_burst #(
        .BURST_LEN (BURST_LEN)
    ) u_burst (
        .word_ofs_i  (ptr_q[11:2]),
        .rem_words_i (rem_q[31:2]),
        .beats_o     (nb_beats),
        .arlen_o     (nb_arlen)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        base_d   = base_q;
        araddr_d = araddr_q;
        rem_d    = rem_q;
        len_d    = len_q;
        arlen_d  = arlen_q;
        beats_d  = beats_q;
        done_d   = done_q;
        err_d    = err_q;
        clrp_d   = clrp_q;
        wr       = 1'b0;

        // Stream bounds are only re-sampled on a clear command
        if (clr_cmd) begin
            base_d = START_ADDR;
            len_d  = DATA_BYTES;
        end

        case (state_q)
            ST_IDLE: begin
                if (clr_cmd) begin
                    ptr_d  = START_ADDR;
                    rem_d  = DATA_BYTES;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    clrp_d = 1'b0;
                end else if (rem_q == 32'd0) begin
`ifdef SND_SRCFETCH_LOOP_EN
                    ptr_d = base_q;
                    rem_d = len_q;
`else
                    done_d = 1'b1;
`endif
                end else if (play_cmd && srcBUF_WREADY && !done_q) begin
                    state_d  = ST_AR;
                    araddr_d = ptr_q;
                    arlen_d  = nb_arlen;
                    beats_d  = nb_beats;
                end
            end
            ST_AR: begin
                if (clr_cmd) clrp_d = 1'b1;
                if (ARREADY) state_d = ST_RD;
            end
            ST_RD: begin
                if (clr_cmd) clrp_d = 1'b1;
                if (RVALID) begin
                    // A clear drains the burst without writing; error beats are still written
                    wr = !clrp_q && !clr_cmd;
                    if (RRESP != RESP_OKAY) err_d = 1'b1;
                    if (RLAST) begin
                        state_d = ST_IDLE;
                        if (clrp_q || clr_cmd) begin
                            ptr_d  = base_d;
                            rem_d  = len_d;
                            done_d = 1'b0;
                            err_d  = 1'b0;
                            clrp_d = 1'b0;
                        end else begin
                            ptr_d = ptr_q + ADDR_W'({beats_q, 2'b00});
                            rem_d = rem_q - {21'd0, beats_q, 2'b00};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q  <= ST_IDLE;
            com_q    <= CMD_STOP;
            ptr_q    <= START_ADDR;
            base_q   <= START_ADDR;
            araddr_q <= '0;
            rem_q    <= DATA_BYTES;
            len_q    <= DATA_BYTES;
            arlen_q  <= '0;
            beats_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clrp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            com_q    <= COMMAND;
            ptr_q    <= ptr_d;
            base_q   <= base_d;
            araddr_q <= araddr_d;
            rem_q    <= rem_d;
            len_q    <= len_d;
            arlen_q  <= arlen_d;
            beats_q  <= beats_d;
            done_q   <= done_d;
            err_q    <= err_d;
            clrp_q   <= clrp_d;
        end
    end

    assign ARADDR     = araddr_q;
    assign ARLEN      = arlen_q;
    assign ARVALID    = (state_q == ST_AR);
    assign RREADY     = (state_q == ST_RD);
    assign srcBUF_WR  = wr;
    assign srcBUF_DIN = wr ? RDATA : 32'd0;
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule
